// File: rtl/lzrw1_stream_parser.sv
// lzrw1_stream_parser: splits an LZRW1 byte stream into control words and literal/copy items for the decompressor.
// Optional LZRW1_PARSER_STATS_EN adds saturating literal/copy/error counters. Rev 1.0
`default_nettype none

module lzrw1_stream_parser #(
  parameter int GROUP_SIZE   = 16,
  parameter int LEN_WIDTH    = 4,
  parameter int OFFSET_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] item_data,
  output logic        item_is_copy,
  output logic        item_valid,
  input  logic        decompressor_busy,
  output logic        stream_done,
  output logic        format_error,
  output logic        parser_busy
`ifdef LZRW1_PARSER_STATS_EN
  ,
  output logic [15:0] stat_literals,
  output logic [15:0] stat_copies,
  output logic [15:0] stat_errors
`endif
);

  localparam int CTRL_BYTES = GROUP_SIZE / 8;
  localparam int IDX_W      = $clog2(GROUP_SIZE);
  localparam int CNT_W      = (CTRL_BYTES > 1) ? $clog2(CTRL_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CTRL_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GROUP_SIZE - 1);

  if ((GROUP_SIZE != 8 && GROUP_SIZE != 16) || (LEN_WIDTH + OFFSET_WIDTH != 16)) begin : g_bad_params
    $error("lzrw1_stream_parser: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    FETCH_CTRL = 2'd0,
    ITEM_B0    = 2'd1,
    ITEM_B1    = 2'd2,
    EMIT       = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [GROUP_SIZE-1:0]   ctrl_reg, ctrl_next;
  logic [IDX_W-1:0]        item_idx, idx_next;
  logic [CNT_W-1:0]        byte_cnt, cnt_next;
  logic [15:0]             data_next;
  logic                    copy_next;
  logic                    last_reg, last_next;

  logic                    byte_accept;
  logic                    item_accept;
  logic [15:0]             copy_word;
  logic                    copy_bad;

  assign in_ready     = (state != EMIT);
  assign item_valid   = (state == EMIT);
  assign parser_busy  = !((state == FETCH_CTRL) && (byte_cnt == '0));
  assign byte_accept  = in_valid && in_ready;
  assign item_accept  = item_valid && !decompressor_busy;

  // The high copy byte is parked in item_data[15:8] until the low byte arrives.
  assign copy_word = {item_data[15:8], in_byte};
  assign copy_bad  = (copy_word[15 -: LEN_WIDTH] == '0) || (copy_word[OFFSET_WIDTH-1:0] == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FETCH_CTRL;
      ctrl_reg     <= '0;
      item_idx     <= '0;
      byte_cnt     <= '0;
      item_data    <= '0;
      item_is_copy <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      state        <= state_next;
      ctrl_reg     <= ctrl_next;
      item_idx     <= idx_next;
      byte_cnt     <= cnt_next;
      item_data    <= data_next;
      item_is_copy <= copy_next;
      last_reg     <= last_next;
    end
  end

  always_comb begin
    state_next   = state;
    ctrl_next    = ctrl_reg;
    idx_next     = item_idx;
    cnt_next     = byte_cnt;
    data_next    = item_data;
    copy_next    = item_is_copy;
    last_next    = last_reg;
    format_error = 1'b0;
    stream_done  = 1'b0;

    case (state)
      FETCH_CTRL: begin
        if (byte_accept) begin
          if (in_last) begin
            format_error = 1'b1;
            cnt_next     = '0;
            ctrl_next    = '0;
          end else begin
            ctrl_next[{byte_cnt, 3'b000} +: 8] = in_byte;
            if (byte_cnt == CNT_LAST) begin
              cnt_next   = '0;
              idx_next   = '0;
              state_next = ITEM_B0;
            end else begin
              cnt_next = byte_cnt + 1'b1;
            end
          end
        end
      end

      ITEM_B0: begin
        if (byte_accept) begin
          if (!ctrl_reg[item_idx]) begin
            data_next  = {8'h00, in_byte};
            copy_next  = 1'b0;
            last_next  = in_last;
            state_next = EMIT;
          end else if (in_last) begin
            format_error = 1'b1;
            state_next   = FETCH_CTRL;
          end else begin
            data_next  = {in_byte, 8'h00};
            state_next = ITEM_B1;
          end
        end
      end

      ITEM_B1: begin
        if (byte_accept) begin
          data_next = copy_word;
          copy_next = 1'b1;
          last_next = in_last;
          if (copy_bad) begin
            format_error = 1'b1;
            last_next    = 1'b0;
            if (in_last) begin
              stream_done = 1'b1;
              state_next  = FETCH_CTRL;
            end else if (item_idx == IDX_LAST) begin
              state_next = FETCH_CTRL;
            end else begin
              idx_next   = item_idx + 1'b1;
              state_next = ITEM_B0;
            end
          end else begin
            state_next = EMIT;
          end
        end
      end

      EMIT: begin
        if (item_accept) begin
          last_next = 1'b0;
          if (last_reg) begin
            stream_done = 1'b1;
            state_next  = FETCH_CTRL;
          end else if (item_idx == IDX_LAST) begin
            state_next = FETCH_CTRL;
          end else begin
            idx_next   = item_idx + 1'b1;
            state_next = ITEM_B0;
          end
        end
      end

      default: state_next = FETCH_CTRL;
    endcase
  end

`ifdef LZRW1_PARSER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_literals <= '0;
      stat_copies   <= '0;
      stat_errors   <= '0;
    end else begin
      if (item_accept && !item_is_copy && (stat_literals != 16'hFFFF))
        stat_literals <= stat_literals + 16'd1;
      if (item_accept && item_is_copy && (stat_copies != 16'hFFFF))
        stat_copies <= stat_copies + 16'd1;
      if (format_error && (stat_errors != 16'hFFFF))
        stat_errors <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
